// File: rtl/mips_pkg.sv
// Shared MIPS HI/LO definitions: funct codes, HI/LO controller state encoding
// and the HI/LO-class funct decode.
package mips_pkg;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MUL_WAIT = 2'd2
  } state_e;

  function automatic logic is_hilo_fn(input logic [5:0] fn);
    case (fn)
      FN_MULTU, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: is_hilo_fn = 1'b1;
      default:                                               is_hilo_fn = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// EX-stage side of the HI/LO unit: instruction issue, flush, stall and
// read-back of the architectural HI/LO registers.
interface hilo_ctrl_if #(parameter int W = 32);
  logic         op_valid;
  logic [5:0]   funct;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         flush;
  logic         stall;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;

  modport master (
    output op_valid, funct, rs_data, rt_data, flush,
    input  stall, rd_data, rd_valid, hi, lo, busy
  );

  modport slave (
    input  op_valid, funct, rs_data, rt_data, flush,
    output stall, rd_data, rd_valid, hi, lo, busy
  );
endinterface

// File: rtl/muldiv_lat_cnt.sv
// Fixed-latency countdown for the multiplier/divider: load, decrement to zero,
// zero flag, synchronous clear.
module muldiv_lat_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Countdown register; saturates at zero so a stray decrement cannot wrap.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/hilo_ctrl.sv
// MIPS HI/LO unit: launches MULTU/DIVU, times their fixed latency, captures the
// 64-bit result into HI/LO, serves MFHI/MFLO/MTHI/MTLO and stalls EX while busy.
module hilo_ctrl #(
  parameter int W       = 32,
  parameter int DIV_LAT = 32,
  parameter int MUL_LAT = 32
) (
  input  logic           clk,
  input  logic           reset,
  hilo_ctrl_if.slave     bus,
  input  logic [2*W-1:0] div_result,
  input  logic [2*W-1:0] mul_result,
  output logic           div_start,
  output logic           mul_start
);
  import mips_pkg::*;

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

  state_e        state_r, state_nxt;
  logic [W-1:0]  hi_r, lo_r, hi_nxt, lo_nxt;
  logic          cnt_clr_s, cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CW-1:0] cnt_val_s;
  logic          op_hl_s;
  logic          div_start_s, mul_start_s, stall_s, rd_valid_s;
  logic [W-1:0]  rd_data_s;

  muldiv_lat_cnt #(.CW(CW)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  assign op_hl_s = bus.op_valid && is_hilo_fn(bus.funct);

  // State and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      hi_r    <= {W{1'b0}};
      lo_r    <= {W{1'b0}};
    end else begin
      state_r <= state_nxt;
      hi_r    <= hi_nxt;
      lo_r    <= lo_nxt;
    end
  end

  // Next-state, HI/LO update and EX-side outputs; flush overrides everything.
  always_comb begin
    state_nxt   = state_r;
    hi_nxt      = hi_r;
    lo_nxt      = lo_r;
    cnt_clr_s   = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    cnt_val_s   = {CW{1'b0}};
    div_start_s = 1'b0;
    mul_start_s = 1'b0;
    stall_s     = 1'b0;
    rd_valid_s  = 1'b0;
    rd_data_s   = {W{1'b0}};
    if (reset) begin
      state_nxt = ST_IDLE;
    end else if (bus.flush) begin
      state_nxt = ST_IDLE;
      cnt_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.funct)
              FN_DIVU: begin
                if (bus.rt_data != {W{1'b0}}) begin
                  div_start_s = 1'b1;
                  cnt_load_s  = 1'b1;
                  cnt_val_s   = DIV_LOAD;
                  state_nxt   = ST_DIV_WAIT;
                end else begin
                  hi_nxt = bus.rs_data;
                  lo_nxt = {W{1'b1}};
                end
              end
              FN_MULTU: begin
                mul_start_s = 1'b1;
                cnt_load_s  = 1'b1;
                cnt_val_s   = MUL_LOAD;
                state_nxt   = ST_MUL_WAIT;
              end
              FN_MTHI: hi_nxt = bus.rs_data;
              FN_MTLO: lo_nxt = bus.rs_data;
              FN_MFHI: begin
                rd_valid_s = 1'b1;
                rd_data_s  = hi_r;
              end
              FN_MFLO: begin
                rd_valid_s = 1'b1;
                rd_data_s  = lo_r;
              end
              default: ;
            endcase
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DIV_WAIT: begin
          stall_s = op_hl_s;
          if (cnt_zero_s) begin
            hi_nxt    = div_result[2*W-1:W];
            lo_nxt    = div_result[W-1:0];
            state_nxt = ST_IDLE;
          end else begin
            cnt_dec_s = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          stall_s = op_hl_s;
          if (cnt_zero_s) begin
            hi_nxt    = mul_result[2*W-1:W];
            lo_nxt    = mul_result[W-1:0];
            state_nxt = ST_IDLE;
          end else begin
            cnt_dec_s = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  assign div_start    = div_start_s;
  assign mul_start    = mul_start_s;
  assign bus.stall    = stall_s;
  assign bus.rd_valid = rd_valid_s;
  assign bus.rd_data  = rd_data_s;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Random and directed bench for hilo_ctrl: reference model of HI/LO timing,
// read-data scoreboard, and behavioural multiplier/divider stubs.
module tb_hilo_ctrl;
  import mips_pkg::*;

  localparam int W       = 32;
  localparam int DIV_LAT = 12;
  localparam int MUL_LAT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] div_result, mul_result;
  logic        div_start, mul_start;

  hilo_ctrl_if #(.W(W)) bus();

  hilo_ctrl #(.W(W), .DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .div_result (div_result),
    .mul_result (mul_result),
    .div_start  (div_start),
    .mul_start  (mul_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [31:0] exp_q[$];

  // Reference model: architectural HI/LO plus one pending long op.
  logic [31:0] hi_m, lo_m, pend_hi, pend_lo;
  bit          pend_valid = 1'b0;
  int          free_cycle = 0;

  // Stub state: operands latched on the start pulse.
  int          d_k = -1000, m_k = -1000;
  logic [31:0] d_a, d_b, m_a, m_b;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) begin
      d_k <= cyc; d_a <= bus.rs_data; d_b <= bus.rt_data;
    end
    if (mul_start) begin
      m_k <= cyc; m_a <= bus.rs_data; m_b <= bus.rt_data;
    end
  end

  // Results are correct only in the cycle the unit is meant to capture them.
  initial begin
    div_result = 64'd0;
    mul_result = 64'd0;
    forever begin
      @(posedge clk); #2;
      if (cyc == d_k + DIV_LAT && d_b != 32'd0) div_result = {d_a % d_b, d_a / d_b};
      else div_result = {$urandom, $urandom};
      if (cyc == m_k + MUL_LAT) mul_result = 64'(m_a) * 64'(m_b);
      else mul_result = {$urandom, $urandom};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no read (cycle %0d)", bus.rd_data, cyc);
      end else begin
        chk("rd_data", 64'(bus.rd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic void commit();
    if (pend_valid && cyc >= free_cycle) begin
      hi_m = pend_hi; lo_m = pend_lo; pend_valid = 1'b0;
    end
  endfunction

  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bit hl;
    logic [63:0] r;
    hl = fn inside {FN_MULTU, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO};
    bus.op_valid = 1'b1; bus.funct = fn; bus.rs_data = a; bus.rt_data = b;
    if (hl) begin
      while (cyc < free_cycle) begin
        @(negedge clk);
        chk("stall_busy", 64'(bus.stall), 64'(1));
        chk("start_busy", 64'({div_start, mul_start}), 64'(0));
        tick();
      end
    end
    commit();
    case (fn)
      FN_MULTU: begin
        r = 64'(a) * 64'(b);
        pend_hi = r[63:32]; pend_lo = r[31:0]; pend_valid = 1'b1;
        free_cycle = cyc + MUL_LAT + 1;
      end
      FN_DIVU: begin
        if (b != 32'd0) begin
          pend_hi = a % b; pend_lo = a / b; pend_valid = 1'b1;
          free_cycle = cyc + DIV_LAT + 1;
        end else begin
          hi_m = a; lo_m = 32'hFFFF_FFFF;
        end
      end
      FN_MTHI: hi_m = a;
      FN_MTLO: lo_m = a;
      FN_MFHI: exp_q.push_back(hi_m);
      FN_MFLO: exp_q.push_back(lo_m);
      default: ;
    endcase
    @(negedge clk);
    chk("stall_accept", 64'(bus.stall), 64'(0));
    chk("div_start", 64'(div_start), 64'(fn == FN_DIVU && b != 32'd0));
    chk("mul_start", 64'(mul_start), 64'(fn == FN_MULTU));
    tick();
    bus.op_valid = 1'b0; bus.funct = 6'd0;
  endtask

  // Flush for one cycle with whatever op is currently on the bus.
  task automatic do_flush();
    commit();
    if (cyc < free_cycle) begin
      pend_valid = 1'b0; free_cycle = cyc + 1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("stall_flush", 64'(bus.stall), 64'(0));
    chk("start_flush", 64'({div_start, mul_start}), 64'(0));
    tick();
    bus.flush = 1'b0; bus.op_valid = 1'b0; bus.funct = 6'd0;
  endtask

  task automatic check_hilo(input string tag);
    commit();
    @(negedge clk);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(hi_m));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(lo_m));
    tick();
  endtask

  initial begin
    int busy_cnt;
    logic [5:0] fns [7];
    fns = '{FN_MULTU, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, 6'd32};
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.funct = 6'd0; bus.rs_data = 32'd0; bus.rt_data = 32'd0; bus.flush = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_outputs", 64'({bus.stall, bus.busy, bus.rd_valid, div_start, mul_start}), 64'(0));
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0; free_cycle = cyc;

    // DIVU 100/7: busy for exactly DIV_LAT cycles, then hi=2, lo=14.
    issue(FN_DIVU, 32'd100, 32'd7);
    busy_cnt = 0;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
      tick();
    end
    chk("div_busy_cycles", 64'(busy_cnt), 64'(DIV_LAT));
    @(negedge clk);
    chk("div_hi_const", 64'(bus.hi), 64'd2);
    chk("div_lo_const", 64'(bus.lo), 64'd14);
    tick();

    // MFLO right behind DIVU stalls until the result is in.
    issue(FN_DIVU, 32'd100, 32'd7);
    issue(FN_MFLO, 32'd0, 32'd0);

    // Divide by zero: no start, immediate HI/LO write.
    issue(FN_DIVU, 32'h1234, 32'd0);
    check_hilo("div0");

    // MULTU flushed with the counter at 10: HI/LO keep prior values.
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (MUL_LAT - 10 - 1) tick();
    do_flush();
    @(negedge clk);
    chk("busy_after_flush", 64'(bus.busy), 64'(0));
    tick();
    repeat (MUL_LAT) tick();
    check_hilo("mul_flush");

    issue(FN_MTHI, 32'hDEAD_BEEF, 32'd0);
    issue(FN_MFHI, 32'd0, 32'd0);

    // Flush in IDLE squashes an MTLO.
    bus.op_valid = 1'b1; bus.funct = FN_MTLO; bus.rs_data = 32'h5555_0000;
    do_flush();
    check_hilo("idle_flush");

    issue(6'd32, 32'h1111, 32'h2222);
    check_hilo("non_hilo");

    // Reset in the middle of a divide discards the result.
    issue(FN_DIVU, 32'd1000, 32'd3);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0; pend_valid = 1'b0; free_cycle = cyc;
    @(negedge clk);
    chk("busy_after_reset", 64'(bus.busy), 64'(0));
    tick();
    check_hilo("reset_mid");
    repeat (DIV_LAT + 2) tick();
    check_hilo("reset_late");

    for (int i = 0; i < 60; i++) begin
      logic [5:0]  fn;
      logic [31:0] a, b;
      fn = fns[$urandom_range(0, 6)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 0) b = b & 32'hFF;
      issue(fn, a, b);
      if (pend_valid && $urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, DIV_LAT)) tick();
        do_flush();
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (MUL_LAT + 2) tick();
    issue(FN_MFHI, 32'd0, 32'd0);
    issue(FN_MFLO, 32'd0, 32'd0);
    check_hilo("final");
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
